// File: rtl/gp_dcmp_pwm_if.sv
`timescale 1ns/1ps
// gp_dcmp_pwm_if: operand/power-down inputs and compare/PWM outputs of the
// digital comparator / deadband PWM cell.
interface gp_dcmp_pwm_if;
  logic       PWRDN;
  logic [7:0] INP;
  logic [7:0] INN;
  logic       GREATER;
  logic       EQUAL;
  logic       OUTP;
  logic       OUTN;

  modport master (output PWRDN, INP, INN, input GREATER, EQUAL, OUTP, OUTN);
  modport slave  (input PWRDN, INP, INN, output GREATER, EQUAL, OUTP, OUTN);
endinterface

// File: rtl/gp_dcmp_pwm.sv
`timescale 1ns/1ps
// gp_dcmp_pwm: clocked 8-bit magnitude comparator with an optional
// complementary PWM pair (programmable deadband) and gated power-down.
module gp_dcmp_pwm #(
  parameter string       MODE             = "DCMP",
  parameter bit          GREATER_OR_EQUAL = 1'b0,
  parameter string       CLK_EDGE         = "RISING",
  parameter bit          PWRDN_SYNC       = 1'b1,
  parameter int unsigned DEADBAND         = 0
) (
  input  logic         CLK,
  input  logic         RST,
  gp_dcmp_pwm_if.slave bus
);
  localparam bit                 IS_PWM  = (MODE == "PWM");
  localparam bit                 FALLING = (CLK_EDGE == "FALLING");
  localparam int unsigned        CNT_W   = 3;
  localparam bit                 DB_ZERO = (DEADBAND == 0);
  localparam logic [CNT_W-1:0]   DB_LOAD = CNT_W'((DEADBAND == 0) ? 0 : DEADBAND - 1);

  // Reject unsupported configurations at elaboration.
  if (MODE != "DCMP" && MODE != "PWM") begin : g_bad_mode
    $fatal(1, "gp_dcmp_pwm: MODE must be DCMP or PWM");
  end
  if (CLK_EDGE != "RISING" && CLK_EDGE != "FALLING") begin : g_bad_edge
    $fatal(1, "gp_dcmp_pwm: CLK_EDGE must be RISING or FALLING");
  end
  if (DEADBAND > 7) begin : g_bad_db
    $fatal(1, "gp_dcmp_pwm: DEADBAND must be 0..7");
  end

  typedef enum logic [2:0] {
    ST_OFF, ST_LOW, ST_DEAD_H, ST_HIGH, ST_DEAD_L
  } state_t;

  logic             clk_s;
  logic             pd;
  logic             greater_d, equal_d, raw;
  logic             greater_q, equal_q, outp_q, outn_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  // Sample clock: every flop in the cell uses the same selected edge.
  if (FALLING) begin : g_clk_fall
    assign clk_s = ~CLK;
  end else begin : g_clk_rise
    assign clk_s = CLK;
  end

  // Effective power-down, optionally through a 2-flop synchronizer that
  // resets to 1 so the cell comes up powered down.
  if (PWRDN_SYNC) begin : g_sync
    logic sync1_q, sync2_q;
    // Synchronizer chain.
    always_ff @(posedge clk_s or posedge RST) begin
      if (RST) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= bus.PWRDN;
        sync2_q <= sync1_q;
      end
    end
    assign pd = sync2_q;
  end else begin : g_nosync
    assign pd = bus.PWRDN;
  end

  // Unsigned compares; raw is the PWM request (counter below duty).
  always_comb begin
    greater_d = GREATER_OR_EQUAL ? (bus.INP >= bus.INN) : (bus.INP > bus.INN);
    equal_d   = (bus.INP == bus.INN);
    raw       = (bus.INP < bus.INN);
  end

  // Comparator flags and deadband FSM; PWM outputs are registered with the
  // state so OUTP/OUTN can never overlap.
  always_ff @(posedge clk_s or posedge RST) begin
    if (RST) begin
      greater_q <= 1'b0;
      equal_q   <= 1'b0;
      outp_q    <= 1'b0;
      outn_q    <= 1'b0;
      state_q   <= ST_OFF;
      cnt_q     <= '0;
    end else if (pd) begin
      greater_q <= 1'b0;
      equal_q   <= 1'b0;
      outp_q    <= 1'b0;
      outn_q    <= 1'b0;
      state_q   <= ST_OFF;
      cnt_q     <= '0;
    end else begin
      greater_q <= greater_d;
      equal_q   <= equal_d;
      if (IS_PWM) begin
        unique case (state_q)
          ST_OFF, ST_LOW, ST_HIGH: begin
            if (raw && (state_q != ST_HIGH)) begin
              if (DB_ZERO) begin
                state_q <= ST_HIGH;
                outp_q  <= 1'b1;
                outn_q  <= 1'b0;
              end else begin
                state_q <= ST_DEAD_H;
                cnt_q   <= DB_LOAD;
                outp_q  <= 1'b0;
                outn_q  <= 1'b0;
              end
            end else if (!raw && (state_q != ST_LOW)) begin
              if (DB_ZERO) begin
                state_q <= ST_LOW;
                outp_q  <= 1'b0;
                outn_q  <= 1'b1;
              end else begin
                state_q <= ST_DEAD_L;
                cnt_q   <= DB_LOAD;
                outp_q  <= 1'b0;
                outn_q  <= 1'b0;
              end
            end
          end
          ST_DEAD_H: begin
            if (!raw) begin
              state_q <= ST_LOW;
              outp_q  <= 1'b0;
              outn_q  <= 1'b1;
            end else if (cnt_q == '0) begin
              state_q <= ST_HIGH;
              outp_q  <= 1'b1;
              outn_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          ST_DEAD_L: begin
            if (raw) begin
              state_q <= ST_HIGH;
              outp_q  <= 1'b1;
              outn_q  <= 1'b0;
            end else if (cnt_q == '0) begin
              state_q <= ST_LOW;
              outp_q  <= 1'b0;
              outn_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          default: begin
            state_q <= ST_OFF;
            outp_q  <= 1'b0;
            outn_q  <= 1'b0;
          end
        endcase
      end else begin
        state_q <= ST_OFF;
        outp_q  <= 1'b0;
        outn_q  <= 1'b0;
      end
    end
  end

  assign bus.GREATER = greater_q;
  assign bus.EQUAL   = equal_q;
  assign bus.OUTP    = outp_q;
  assign bus.OUTN    = outn_q;
endmodule
